// File: rtl/pmp_pkg.sv
// pmp_pkg: PMP cfg/address-mode/error types, CSR base constants and cfg byte packing.
package pmp_pkg;
  typedef enum logic [1:0] {A_OFF, A_TOR, A_NA4, A_NAPOT} pmp_a_e;
  typedef enum logic [2:0] {ERR_OK, ERR_BAD_IDX, ERR_BAD_SIZE, ERR_MISALIGN, ERR_TIMEOUT} pmp_err_e;
  typedef struct packed {
    logic       l;
    logic [1:0] rsv;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;
  localparam logic [11:0] PMPADDR_BASE_DEF = 12'h3B0;
  localparam logic [11:0] PMPCFG_BASE_DEF  = 12'h3A0;
  function automatic pmp_cfg_t pack_cfg(input logic l, input pmp_a_e a, input logic [2:0] perm);
    pack_cfg = '{l: l, rsv: 2'b00, a: a, x: perm[2], w: perm[1], r: perm[0]};
  endfunction
endpackage

// File: rtl/pmp_napot_programmer.sv
// pmp_napot_programmer: encodes a region request into NAPOT pmpaddr/pmpcfg CSR writes.
// Define PMP_NA4_EN to accept 4-byte (NA4) regions.
module pmp_napot_programmer import pmp_pkg::*; #(
  parameter int          NUM_ENTRIES  = 16,
  parameter logic [11:0] PMPADDR_BASE = PMPADDR_BASE_DEF,
  parameter logic [11:0] PMPCFG_BASE  = PMPCFG_BASE_DEF,
  parameter int          ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_base,
  input  logic [5:0]  req_log2sz,
  input  logic [3:0]  req_idx,
  input  logic [2:0]  req_perm,
  input  logic        req_lock,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic [3:0]  csr_be,
  input  logic        csr_ack,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_err
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ENCODE, S_WR_ADDR, S_WR_CFG, S_RESP} state_e;
  localparam int WW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
`ifdef PMP_NA4_EN
  localparam logic [5:0] MIN_K = 6'd2;
`else
  localparam logic [5:0] MIN_K = 6'd3;
`endif
  state_e        state_q, state_d;
  logic [31:0]   base_q, base_d, acc_q, acc_d, mask_q, mask_d;
  logic [5:0]    k_q, k_d, cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [2:0]    perm_q, perm_d;
  logic          lock_q, lock_d, gap_q, gap_d;
  logic [WW-1:0] wait_q, wait_d;
  pmp_err_e      err_q, err_d;
  logic          na4, bad_idx, bad_size, misalign, wr_addr;
  pmp_cfg_t      cfg;
  assign na4      = k_q == 6'd2;
  assign bad_idx  = {28'd0, idx_q} >= 32'(NUM_ENTRIES);
  assign bad_size = k_q < MIN_K || k_q > 6'd32;
  assign misalign = |(base_q & ~(32'hFFFF_FFFF << k_q));
  assign wr_addr  = state_q == S_WR_ADDR;
  assign cfg      = pack_cfg(lock_q, na4 ? A_NA4 : A_NAPOT, perm_q);
  assign req_ready = state_q == S_IDLE;
  // WR_CFG spends its first cycle with the strobe low so writes never run back to back
  assign csr_we    = wr_addr || (state_q == S_WR_CFG && !gap_q);
  assign csr_addr  = !csr_we ? 12'd0 : wr_addr ? PMPADDR_BASE + {8'd0, idx_q} : PMPCFG_BASE + {10'd0, idx_q[3:2]};
  assign csr_wdata = !csr_we ? 32'd0 : wr_addr ? acc_q : {24'd0, cfg} << {idx_q[1:0], 3'b000};
  assign csr_be    = !csr_we ? 4'd0 : wr_addr ? 4'hF : 4'b0001 << idx_q[1:0];
  assign rsp_valid = state_q == S_RESP;
  assign rsp_err   = err_q;
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    k_d     = k_q;
    idx_d   = idx_q;
    perm_d  = perm_q;
    lock_d  = lock_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    gap_d   = gap_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        base_d  = req_base;
        k_d     = req_log2sz;
        idx_d   = req_idx;
        perm_d  = req_perm;
        lock_d  = req_lock;
        err_d   = ERR_OK;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_RESP;
        if (bad_idx) err_d = ERR_BAD_IDX;
        else if (bad_size) err_d = ERR_BAD_SIZE;
        else if (misalign) err_d = ERR_MISALIGN;
        else begin
          state_d = S_ENCODE;
          acc_d   = {2'b00, base_q[31:2]};
          mask_d  = 32'd1;
          cnt_d   = na4 ? 6'd0 : k_q - 6'd3;
        end
      end
      S_ENCODE: begin
        if (cnt_q != 6'd0) begin
          acc_d  = acc_q | mask_q;
          mask_d = mask_q << 1;
          cnt_d  = cnt_q - 6'd1;
        end
        if (cnt_q <= 6'd1) begin
          state_d = S_WR_ADDR;
          wait_d  = '0;
        end
      end
      S_WR_ADDR, S_WR_CFG: begin
        if (gap_q) gap_d = 1'b0;
        else if (csr_ack) begin
          state_d = wr_addr ? S_WR_CFG : S_RESP;
          gap_d   = wr_addr;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_RESP;
        end else wait_d = wait_q + 1'b1;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      perm_q  <= '0;
      lock_q  <= 1'b0;
      acc_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      gap_q   <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      perm_q  <= perm_d;
      lock_q  <= lock_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_pmp_napot_programmer.sv
// tb_pmp_napot_programmer: vector table, randomized model check and reset/timeout sequences.
module tb_pmp_napot_programmer;
  localparam int TO = 255;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_lock = 0, csr_ack = 0, rsp_ready = 0;
  logic [31:0] req_base = 0;
  logic [5:0]  req_log2sz = 0;
  logic [3:0]  req_idx = 0;
  logic [2:0]  req_perm = 0;
  logic        req_ready, csr_we, rsp_valid;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [3:0]  csr_be;
  logic [2:0]  rsp_err;
  logic        req_valid2 = 0, rsp_ready2 = 0;
  logic        req_ready2, csr_we2, rsp_valid2;
  logic [11:0] csr_addr2;
  logic [31:0] csr_wdata2;
  logic [3:0]  csr_be2;
  logic [2:0]  rsp_err2;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  pmp_napot_programmer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
    .req_log2sz(req_log2sz), .req_idx(req_idx), .req_perm(req_perm), .req_lock(req_lock),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_be(csr_be),
    .csr_ack(csr_ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err));

  // Eight-entry instance so that out-of-range indices are reachable on a 4-bit port
  pmp_napot_programmer #(.NUM_ENTRIES(8)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_base(req_base),
    .req_log2sz(req_log2sz), .req_idx(req_idx), .req_perm(req_perm), .req_lock(req_lock),
    .csr_we(csr_we2), .csr_addr(csr_addr2), .csr_wdata(csr_wdata2), .csr_be(csr_be2),
    .csr_ack(csr_ack), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_err(rsp_err2));

  typedef struct {
    int          err;
    logic [31:0] pd;
    logic [11:0] ca;
    logic [3:0]  cbe;
    logic [31:0] cd;
    int          lat;
  } exp_t;
  typedef struct {
    logic [31:0] b;
    logic [5:0]  k;
    logic [3:0]  i;
    logic [2:0]  p;
    logic        l;
    int          mode;
    exp_t        e;
  } vec_t;
  typedef struct {
    int          err, nw, lat, dur0, dur1;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  be0, be1;
    bit          stable, gap, rsp_stable;
  } obs_t;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] b, input int k, input int idx, input int perm, input int l);
    exp_t e;
    int min_k, a, cfg;
`ifdef PMP_NA4_EN
    min_k = 2;
`else
    min_k = 3;
`endif
    e = '{default: 0};
    if (idx >= 16) e.err = 1;
    else if (k < min_k || k > 32) e.err = 2;
    else if (longint'(b) % (longint'(1) << k) != 0) e.err = 3;
    if (e.err != 0) return e;
    e.pd  = (k == 2) ? b / 4 : 32'(longint'(b / 4) + (longint'(1) << (k - 3)) - 1);
    a     = (k == 2) ? 2 : 3;
    cfg   = l * 128 + a * 8 + perm;
    e.cd  = 32'(longint'(cfg) * (longint'(1) << (8 * (idx % 4))));
    e.cbe = 4'(1 << (idx % 4));
    e.ca  = 12'(32'h3A0 + idx / 4);
    e.lat = 1 + ((k - 3 > 1) ? k - 3 : 1);
    return e;
  endfunction

  // mode 0: ack after dly cycles; 1: never ack; 2: ack pmpaddr only
  task automatic run(input logic [31:0] b, input logic [5:0] k, input logic [3:0] i, input logic [2:0] p,
                     input logic l, input int mode, input int dly, input int hold, output obs_t o);
    int edges, wc;
    bit prev_we, prev_ack;
    logic [11:0] ca;
    logic [31:0] cd;
    logic [3:0]  cb;
    o = '{default: 0};
    o.stable = 1; o.gap = 1; o.rsp_stable = 1; o.lat = -1; o.err = -1;
    req_base = b; req_log2sz = k; req_idx = i; req_perm = p; req_lock = l; req_valid = 1;
    edges = 0;
    while (!req_ready && edges < 50) begin @(posedge clk); #1; edges++; end
    @(posedge clk); #1;
    req_valid = 0;
    edges = 0; prev_we = 0; prev_ack = 0; wc = 0; ca = 0; cd = 0; cb = 0;
    while (!rsp_valid && edges < 3000) begin
      if (csr_we) begin
        if (prev_we && prev_ack) o.gap = 0;
        if (!prev_we || prev_ack) begin
          o.nw++; wc = 0; ca = csr_addr; cd = csr_wdata; cb = csr_be;
          if (o.lat < 0) o.lat = edges;
          if (o.nw == 1) begin o.a0 = ca; o.d0 = cd; o.be0 = cb; end
          else begin o.a1 = ca; o.d1 = cd; o.be1 = cb; end
        end else if ({csr_addr, csr_wdata, csr_be} !== {ca, cd, cb}) o.stable = 0;
        wc++;
        if (o.nw == 1) o.dur0 = wc; else o.dur1 = wc;
        csr_ack = (mode == 1 || (mode == 2 && o.nw >= 2)) ? 1'b0 : (wc - 1 >= dly);
      end else csr_ack = 0;
      prev_we = csr_we; prev_ack = csr_ack;
      @(posedge clk); #1;
      edges++;
    end
    csr_ack = 0;
    chk("rsp_seen", rsp_valid, 1);
    o.err = int'(rsp_err);
    repeat (hold) begin
      @(posedge clk); #1;
      if (!rsp_valid || int'(rsp_err) != o.err) o.rsp_stable = 0;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("rsp_done", {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic check_obs(input string n, input logic [3:0] i, input int mode, input int dly, input exp_t e, input obs_t o);
    chk($sformatf("%s.err", n), o.err, e.err);
    chk($sformatf("%s.rsp_hold", n), o.rsp_stable, 1);
    if (e.err == 0 || e.err == 4) begin
      chk($sformatf("%s.lat", n), o.lat, e.lat);
      chk($sformatf("%s.nwr", n), o.nw, (mode == 1) ? 1 : 2);
      chk($sformatf("%s.a_addr", n), o.a0, 12'h3B0 + {8'd0, i});
      chk($sformatf("%s.a_data", n), o.d0, e.pd);
      chk($sformatf("%s.a_be", n), o.be0, 4'hF);
      chk($sformatf("%s.a_dur", n), o.dur0, (mode == 1) ? TO : dly + 1);
      if (mode != 1) begin
        chk($sformatf("%s.c_addr", n), o.a1, e.ca);
        chk($sformatf("%s.c_data", n), o.d1, e.cd);
        chk($sformatf("%s.c_be", n), o.be1, e.cbe);
        chk($sformatf("%s.c_dur", n), o.dur1, (mode == 2) ? TO : dly + 1);
      end
      chk($sformatf("%s.stable", n), o.stable, 1);
      chk($sformatf("%s.gap", n), o.gap, 1);
    end else chk($sformatf("%s.nwr", n), o.nw, 0);
  endtask

  task automatic run2(input logic [3:0] i, input int exp_err);
    int edges;
    req_base = 32'h0000_1000; req_log2sz = 6'd12; req_idx = i; req_perm = 3'b001; req_lock = 0;
    csr_ack = 1; req_valid2 = 1;
    @(posedge clk); #1;
    req_valid2 = 0;
    edges = 0;
    while (!rsp_valid2 && edges < 100) begin @(posedge clk); #1; edges++; end
    chk($sformatf("idx%0d.err", i), {rsp_valid2, rsp_err2}, {1'b1, 3'(exp_err)});
    rsp_ready2 = 1;
    @(posedge clk); #1;
    rsp_ready2 = 0; csr_ack = 0;
  endtask

  vec_t vecs[10];
  obs_t o;
  exp_t e;

  initial begin
    vecs[0] = '{32'h8000_0000, 6'd12, 4'd2, 3'b011, 1'b0, 0, '{0, 32'h2000_01FF, 12'h3A0, 4'b0100, 32'h001B_0000, 10}};
    vecs[1] = '{32'h8000_0100, 6'd12, 4'd2, 3'b011, 1'b0, 0, '{3, 0, 0, 0, 0, 0}};
    vecs[2] = '{32'h0000_0000, 6'd32, 4'd15, 3'b111, 1'b1, 0, '{0, 32'h1FFF_FFFF, 12'h3A3, 4'b1000, 32'h9F00_0000, 30}};
`ifdef PMP_NA4_EN
    vecs[3] = '{32'h0000_1004, 6'd2, 4'd0, 3'b001, 1'b0, 0, '{0, 32'h0000_0401, 12'h3A0, 4'b0001, 32'h0000_0011, 2}};
`else
    vecs[3] = '{32'h0000_1004, 6'd2, 4'd0, 3'b001, 1'b0, 0, '{2, 0, 0, 0, 0, 0}};
`endif
    vecs[4] = '{32'h0000_1000, 6'd3, 4'd5, 3'b101, 1'b0, 0, '{0, 32'h0000_0400, 12'h3A1, 4'b0010, 32'h0000_1D00, 2}};
    vecs[5] = '{32'h0000_0040, 6'd33, 4'd0, 3'b001, 1'b0, 0, '{2, 0, 0, 0, 0, 0}};
    vecs[6] = '{32'h0000_0040, 6'd6, 4'd1, 3'b010, 1'b0, 1, '{4, 32'h0000_0017, 12'h3A0, 4'b0010, 32'h0000_1A00, 4}};
    vecs[7] = '{32'h0000_0000, 6'd1, 4'd0, 3'b001, 1'b0, 0, '{2, 0, 0, 0, 0, 0}};
    vecs[8] = '{32'h0000_0100, 6'd8, 4'd3, 3'b100, 1'b1, 2, '{4, 32'h0000_005F, 12'h3A0, 4'b1000, 32'h9C00_0000, 6}};
    vecs[9] = '{32'h0000_1000, 6'd32, 4'd0, 3'b001, 1'b0, 0, '{3, 0, 0, 0, 0, 0}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {req_ready, csr_we, csr_addr, csr_wdata, csr_be, rsp_valid, rsp_err},
        {1'b1, 1'b0, 12'd0, 32'd0, 4'd0, 1'b0, 3'd0});
    rst = 0;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      run(vecs[v].b, vecs[v].k, vecs[v].i, vecs[v].p, vecs[v].l, vecs[v].mode, v % 3, (v == 6) ? 5 : v % 2, o);
      check_obs($sformatf("vec%0d", v), vecs[v].i, vecs[v].mode, v % 3, vecs[v].e, o);
    end

    for (int r = 0; r < 40; r++) begin
      logic [31:0] b;
      int k, idx, perm, l, mode, dly;
      k = $urandom_range(1, 34);
      b = $urandom;
      if ($urandom_range(0, 3) != 0 && k <= 32) b = 32'(longint'(b) & ~((longint'(1) << k) - 1));
      idx = $urandom_range(0, 15); perm = $urandom_range(0, 7); l = $urandom_range(0, 1);
      mode = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      dly = $urandom_range(0, 3);
      e = model(b, k, idx, perm, l);
      if (mode != 0 && e.err == 0) e.err = 4;
      run(b, 6'(k), 4'(idx), 3'(perm), 1'(l), mode, dly, $urandom_range(0, 3), o);
      check_obs($sformatf("rnd%0d", r), 4'(idx), mode, dly, e, o);
    end

    // reset while ENCODE is running aborts the request silently
    begin
      bit seen;
      req_base = 32'h0010_0000; req_log2sz = 6'd20; req_idx = 4'd4; req_perm = 3'b011; req_lock = 0;
      req_valid = 1;
      @(posedge clk); #1;
      req_valid = 0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk); #1;
      chk("rst_mid_encode", {req_ready, csr_we, csr_addr, csr_wdata, csr_be, rsp_valid, rsp_err},
          {1'b1, 1'b0, 12'd0, 32'd0, 4'd0, 1'b0, 3'd0});
      rst = 0;
      seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (csr_we || rsp_valid) seen = 1;
      end
      chk("rst_no_activity", seen, 0);
      e = model(32'h0010_0000, 20, 4, 3, 0);
      run(32'h0010_0000, 6'd20, 4'd4, 3'b011, 1'b0, 0, 1, 2, o);
      check_obs("post_rst", 4'd4, 0, 1, e, o);
    end

    run2(4'd8, 1);
    run2(4'd15, 1);
    run2(4'd7, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
